pc_unit: RTL

Parametrised program-counter unit for the pipelined MIPS-Lite CPU, replacing the plain load-every-cycle PC register at the head of the IF stage. It holds the fetch address and advances it by a fixed increment. It freezes under hazard-unit stall and accepts branch, jump and exception redirects with fixed priority. A redirect that arrives during a stall is buffered and applied in the cycle the stall releases.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_redirect_sel.sv | 61 ++++++
 rtl/pc_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// Holds:
//   - the FSM state encoding (BOOT, RUN, PEND)
//   - the redirect-source encoding (NONE, EXC, BR, JMP)
//   - the default width, increment and vector constants
// Redirect sources are numbered so that a larger value means a higher
// priority. Priority comparisons can then use a plain ">=".
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_e;

    localparam int          DEF_WIDTH        = 32;
    localparam int          DEF_INCR         = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect resolver.
// Picks the winning redirect with priority exc > br_taken > jump, then checks
// that the winning target is aligned to INCR.
// Ports:
//   exc, br_taken, br_target, jump, jump_target : redirect requests
//   target   : resolved target (EXC_VECTOR for exc or a misaligned target)
//   src      : winning source, a redir_src_e value (SRC_NONE if no request)
//   misalign : the winning branch or jump target was misaligned
module pc_redirect_sel
    import pc_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               INCR       = DEF_INCR,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic             exc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] target,
    output logic [1:0]       src,
    output logic             misalign
);

    // INCR is a power of two, so INCR-1 masks exactly the low log2(INCR) bits.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INCR - 1);

    redir_src_e       src_e;
    logic [WIDTH-1:0] raw_target;

    always_comb begin
        src_e      = SRC_NONE;
        raw_target = '0;
        target     = '0;
        misalign   = 1'b0;
        if (exc) begin
            src_e = SRC_EXC;
        end else if (br_taken) begin
            src_e      = SRC_BR;
            raw_target = br_target;
        end else if (jump) begin
            src_e      = SRC_JMP;
            raw_target = jump_target;
        end

        if (src_e == SRC_EXC) begin
            target = EXC_VECTOR;
        end else if (src_e != SRC_NONE) begin
            // A misaligned branch or jump target is turned into an exception.
            if ((raw_target & ALIGN_MASK) != '0) begin
                target   = EXC_VECTOR;
                misalign = 1'b1;
            end else begin
                target = raw_target;
            end
        end
        src = src_e;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the IF stage.
// The PC advances by INCR every cycle, freezes while the hazard unit stalls,
// and takes exc, branch or jump redirects. A redirect that arrives during a
// stall is held in a pending register and applied when the stall releases.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   stall               : hold the PC
//   br_taken/br_target  : branch redirect
//   jump/jump_target    : jump redirect
//   exc                 : exception redirect to EXC_VECTOR
//   pc, pc_plus         : fetch address and fetch address + INCR
//   pc_valid            : fetch address is on the live path (RUN state)
//   misalign            : one-cycle pulse for a misaligned accepted target
//   dbg_state           : current FSM state (pc_state_e encoding)
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               INCR         = DEF_INCR,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pc_valid,
    output logic             misalign,
    output logic [1:0]       dbg_state
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [1:0]       pend_src_q, pend_src_d;
    logic             pc_valid_q, pc_valid_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] sel_target;
    logic [1:0]       sel_src;
    logic             sel_misalign;

    pc_redirect_sel #(
        .WIDTH      (WIDTH),
        .INCR       (INCR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .exc         (exc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .target      (sel_target),
        .src         (sel_src),
        .misalign    (sel_misalign)
    );

    assign pc_plus = pc_q + WIDTH'(INCR);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_src_d = pend_src_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    pc_d       = (sel_src != SRC_NONE) ? sel_target : pc_plus;
                    misalign_d = sel_misalign;
                end else if (sel_src != SRC_NONE) begin
                    pend_d     = sel_target;
                    pend_src_d = sel_src;
                    misalign_d = sel_misalign;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    // Only an equal- or higher-priority request replaces the pending one.
                    if (sel_src != SRC_NONE && sel_src >= pend_src_q) begin
                        pend_d     = sel_target;
                        pend_src_d = sel_src;
                        misalign_d = sel_misalign;
                    end
                end else begin
                    // On release the pending target is applied. A fresh exc still wins.
                    pc_d       = (sel_src == SRC_EXC) ? EXC_VECTOR : pend_q;
                    pend_d     = '0;
                    pend_src_d = SRC_NONE;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pend_src_q <= SRC_NONE;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign misalign  = misalign_q;
    assign dbg_state = state_q;

endmodule
